ssd_scan_driver: RTL

//  Downstream of the CPU's memory-mapped display registers. Takes the four 4-bit digit

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/hex_to_seg7.sv | 15 +
 rtl/ssd_scan_driver.sv | 114 +++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// hex7 patterns are active-low, ordered {g,f,e,d,c,b,a}.
`timescale 1ns/1ps
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  localparam seg7_t HEX7_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // One frame's worth of display content, captured together so a frame never mixes values.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digit;
    logic [NUM_DIGITS-1:0]      dp;
  } snapshot_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit value to active-low 7-segment pattern lookup.
`timescale 1ns/1ps
module hex_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  // Plain table lookup; every 4-bit value has a defined glyph.
  always_comb begin
    seg = HEX7_TABLE[hex];
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Digits are captured once per frame and each slot starts with a blanking gap.
// Optional feature: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
`timescale 1ns/1ps
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] ssd0,
  input  logic [3:0] ssd1,
  input  logic [3:0] ssd2,
  input  logic [3:0] ssd3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [1:0]            idx, idx_next;
  snapshot_t             snap, snap_next;
  logic                  reload, reload_next;
  logic [3:0]            an_next;
  seg7_t                 seg_next;
  logic                  dp_next;
  logic [3:0]            digit_next;
  seg7_t                 digit_seg;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign digit_next = snap_next.digit[idx_next];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit_next),
    .seg (digit_seg)
  );

  // Advance the slot counter and digit index; capture a fresh snapshot at frame start or restart.
  always_comb begin
    cnt_next    = '0;
    idx_next    = '0;
    snap_next   = snap;
    reload_next = 1'b1;
    if (en) begin
      reload_next = 1'b0;
      if (cnt == CNT_MAX) begin
        cnt_next = '0;
        idx_next = idx + 2'd1;
      end else begin
        cnt_next = cnt + 1'b1;
        idx_next = idx;
      end
      if (reload || (cnt == CNT_MAX && idx == 2'd3)) begin
        snap_next.digit = {ssd3, ssd2, ssd1, ssd0};
        snap_next.dp    = dp_in;
      end
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = (snap_next.digit[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_next.digit[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_next.digit[1] == 4'd0);
  end
`else
  assign lz_blank = '0;
`endif

  // Derive the next registered outputs from the next state so they move with cnt/idx.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (en && cnt_next >= CNT_BLANK) begin
      an_next  = ~(4'b0001 << idx_next);
      seg_next = lz_blank[idx_next] ? SEG_BLANK : digit_seg;
      dp_next  = ~snap_next.dp[idx_next];
    end
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      snap   <= '0;
      reload <= 1'b1;
      an     <= AN_OFF;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
    end else begin
      cnt    <= cnt_next;
      idx    <= idx_next;
      snap   <= snap_next;
      reload <= reload_next;
      an     <= an_next;
      seg    <= seg_next;
      dp     <= dp_next;
    end
  end

endmodule
